dmem_port_arbiter: RTL and testbench

//  Shares the single data-memory port between the two issue slots of the dual-issue pipeline.

---
 rtl/dmem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares the single data-memory port between the two issue slots,
//            serving the older slot 0 first and stalling until both finish.
// Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wd0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          stall
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT0  = 2'd1;
    localparam logic [1:0] c_WAIT1  = 2'd2;
    localparam logic [1:0] c_ISSUE1 = 2'd3;

    // The counter holds the number of wait cycles still to go after the
    // current one, so a load spends exactly MEM_LAT cycles on the port.
    localparam logic [1:0] c_CNT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;
    localparam logic       c_ASYNC_RD = (MEM_LAT == 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [1:0]    r_cnt;
    logic [DW-1:0] r_rd0;
    logic [DW-1:0] r_rd1;

    logic          w_active;
    logic          w_slot;
    logic          w_issue;
    logic          w_we;
    logic [AW-1:0] w_adr;
    logic [DW-1:0] w_wd;
    logic          w_finish;
    logic          w_last;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latency counter and load-data capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 2'd0;
            r_rd0 <= '0;
            r_rd1 <= '0;
        end else begin
            if (w_issue && !w_finish) begin
                r_cnt <= c_CNT_INIT;
            end else if (w_active && !w_issue && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_finish && !w_we && !w_slot) begin
                r_rd0 <= mem_rd;
            end
            if (w_finish && !w_we && w_slot) begin
                r_rd1 <= mem_rd;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (w_active) begin
            if (!w_slot) begin
                if (w_finish) begin
                    w_next = req1 ? c_ISSUE1 : c_IDLE;
                end else begin
                    w_next = c_WAIT0;
                end
            end else begin
                w_next = w_finish ? c_IDLE : c_WAIT1;
            end
        end
    end

    // Output logic; reset gates every output so it takes effect mid-cycle
    always_comb begin
        w_active = 1'b0;
        w_slot   = 1'b0;
        w_issue  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_active = req0 | req1;
                w_slot   = ~req0;
                w_issue  = req0 | req1;
            end
            c_WAIT0: begin
                w_active = 1'b1;
                w_slot   = 1'b0;
            end
            c_WAIT1: begin
                w_active = 1'b1;
                w_slot   = 1'b1;
            end
            c_ISSUE1: begin
                w_active = 1'b1;
                w_slot   = 1'b1;
                w_issue  = 1'b1;
            end
            default: begin
                w_active = 1'b0;
            end
        endcase

        w_we     = w_slot ? we1  : we0;
        w_adr    = w_slot ? adr1 : adr0;
        w_wd     = w_slot ? wd1  : wd0;
        w_finish = w_active & (w_issue ? (w_we | c_ASYNC_RD) : (r_cnt == 2'd0));
        // Slot 0 finishing is only the end of the pair when slot 1 has nothing to do
        w_last   = w_slot | ~req1;

        mem_en  = reset & w_issue;
        mem_we  = reset & w_active & w_we;
        mem_adr = (reset && w_active) ? w_adr : '0;
        mem_wd  = (reset && w_active) ? w_wd  : '0;
        stall   = reset & w_active & ~(w_finish & w_last);
        rd0     = (reset && w_finish && !w_we && !w_slot) ? mem_rd : r_rd0;
        rd1     = (reset && w_finish && !w_we &&  w_slot) ? mem_rd : r_rd1;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Purpose  : Scoreboard bench for dmem_port_arbiter at MEM_LAT=1 and MEM_LAT=3.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int NDUT = 2;

    logic        clk = 1'b0;
    logic        reset;
    int          cur;
    logic        req0, we0, req1, we1;
    logic [31:0] adr0, wd0, adr1, wd1;

    logic        mem_en_o  [NDUT];
    logic        mem_we_o  [NDUT];
    logic [31:0] mem_adr_o [NDUT];
    logic [31:0] mem_wd_o  [NDUT];
    logic [31:0] rd0_o     [NDUT];
    logic [31:0] rd1_o     [NDUT];
    logic        stall_o   [NDUT];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Instance 0 runs with an async-read memory, instance 1 with 3-cycle loads
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem [0:63];
        logic [31:0] mem_rd;
        logic [31:0] last_adr = 32'd0;
        logic [31:0] rd_adr;
        int          age = 8;
        int          k;
        logic        r0g, r1g;

        assign r0g = req0 && (cur == g);
        assign r1g = req1 && (cur == g);

        dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
            .clk     (clk),
            .reset   (reset),
            .req0    (r0g),
            .we0     (we0),
            .adr0    (adr0),
            .wd0     (wd0),
            .req1    (r1g),
            .we1     (we1),
            .adr1    (adr1),
            .wd1     (wd1),
            .mem_en  (mem_en_o[g]),
            .mem_we  (mem_we_o[g]),
            .mem_adr (mem_adr_o[g]),
            .mem_wd  (mem_wd_o[g]),
            .mem_rd  (mem_rd),
            .rd0     (rd0_o[g]),
            .rd1     (rd1_o[g]),
            .stall   (stall_o[g])
        );

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        end

        always @(posedge clk) begin
            if (mem_en_o[g] && mem_we_o[g]) mem[mem_adr_o[g][7:2]] <= mem_wd_o[g];
            if (mem_en_o[g]) begin
                age      <= 1;
                last_adr <= mem_adr_o[g];
            end else if (age < 8) begin
                age <= age + 1;
            end
        end

        // Read data is garbage until LAT-1 cycles after the strobe
        always_comb begin
            k      = mem_en_o[g] ? 0 : age;
            rd_adr = mem_en_o[g] ? mem_adr_o[g] : last_adr;
            mem_rd = (k >= LAT - 1) ? mem[rd_adr[7:2]] : (32'hBAD0_0000 | 32'(k));
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
    } acc_t;

    typedef struct {
        int          cycles;
        logic        ld0;
        logic        ld1;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } done_t;

    acc_t        accq[$];
    done_t       doneq[$];
    logic [31:0] refmem [0:63];
    int          checks = 0;
    int          passes = 0;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    logic [31:0] held0 = 32'd0;
    logic [31:0] held1 = 32'd0;
    logic [31:0] cur_adr = 32'd0;
    acc_t        m_acc;
    done_t       m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (dut %0d, t=%0t)", name, act, exp, cur, $time);
    endtask

    // Monitor: pops expected accesses on each strobe and expected results when a pair ends
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_en_o[cur]) begin
                if (accq.size() == 0) begin
                    chk("mem_en_unexpected", 32'(mem_en_o[cur]), 32'd0);
                end else begin
                    m_acc = accq.pop_front();
                    chk("mem_we", 32'(mem_we_o[cur]), 32'(m_acc.we));
                    chk("mem_adr", mem_adr_o[cur], m_acc.adr);
                    if (m_acc.we) chk("mem_wd", mem_wd_o[cur], m_acc.wd);
                    cur_adr = m_acc.adr;
                end
            end else if (req0 || req1) begin
                chk("wait_adr", mem_adr_o[cur], cur_adr);
                chk("wait_we", 32'(mem_we_o[cur]), 32'd0);
            end
            if (req0 || req1) begin
                cyc++;
                if (!stall_o[cur]) begin
                    if (doneq.size() == 0) begin
                        chk("done_unexpected", 32'(stall_o[cur]), 32'd1);
                    end else begin
                        m_done = doneq.pop_front();
                        chk("pair_cycles", 32'(cyc), 32'(m_done.cycles));
                        if (m_done.ld0) held0 = m_done.rd0;
                        if (m_done.ld1) held1 = m_done.rd1;
                        chk("rd0", rd0_o[cur], held0);
                        chk("rd1", rd1_o[cur], held1);
                    end
                    cyc = 0;
                end
            end else begin
                chk("idle_stall", 32'(stall_o[cur]), 32'd0);
                chk("idle_en", 32'(mem_en_o[cur]), 32'd0);
                chk("idle_adr", mem_adr_o[cur], 32'd0);
                chk("idle_rd0", rd0_o[cur], held0);
                chk("idle_rd1", rd1_o[cur], held1);
            end
        end
    end

    // Reference: slot 0 then slot 1 applied to a flat memory; stores cost 1, loads MEM_LAT
    task automatic do_pair(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        done_t e;
        acc_t  x;
        int    lat;
        int    n;
        lat = (cur == 0) ? 1 : 3;
        e.cycles = 0; e.ld0 = 1'b0; e.ld1 = 1'b0; e.rd0 = 32'd0; e.rd1 = 32'd0;
        if (r0) begin
            x.we = w0; x.adr = a0; x.wd = d0;
            accq.push_back(x);
            if (w0) begin
                refmem[a0[7:2]] = d0;
                e.cycles += 1;
            end else begin
                e.ld0 = 1'b1; e.rd0 = refmem[a0[7:2]];
                e.cycles += lat;
            end
        end
        if (r1) begin
            x.we = w1; x.adr = a1; x.wd = d1;
            accq.push_back(x);
            if (w1) begin
                refmem[a1[7:2]] = d1;
                e.cycles += 1;
            end else begin
                e.ld1 = 1'b1; e.rd1 = refmem[a1[7:2]];
                e.cycles += lat;
            end
        end
        doneq.push_back(e);
        @(posedge clk); #1;
        req0 = r0; we0 = w0; adr0 = a0; wd0 = d0;
        req1 = r1; we1 = w1; adr1 = a1; wd1 = d1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_o[cur] && n < 50);
        if (stall_o[cur]) chk("stall_timeout", 32'(stall_o[cur]), 32'd0);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic rand_pair();
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        r0 = 1'($urandom_range(0, 1));
        r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
        w0 = 1'($urandom_range(0, 1));
        w1 = 1'($urandom_range(0, 1));
        a0 = 32'h10 + 32'(4 * $urandom_range(0, 7));
        a1 = 32'h10 + 32'(4 * $urandom_range(0, 7));
        d0 = $urandom;
        d1 = $urandom;
        do_pair(r0, w0, a0, d0, r1, w1, a1, d1);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; cur = 0;
        req0 = 1'b0; we0 = 1'b0; adr0 = 32'd0; wd0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; adr1 = 32'd0; wd1 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_stall", 32'(stall_o[d]), 32'd0);
            chk("reset_en", 32'(mem_en_o[d]), 32'd0);
            chk("reset_rd0", rd0_o[d], 32'd0);
            chk("reset_rd1", rd1_o[d], 32'd0);
        end
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int p = 0; p < NDUT; p++) begin
            @(posedge clk); #1;
            cur = p; held0 = 32'd0; held1 = 32'd0; cyc = 0;
            for (int i = 0; i < 64; i++) refmem[i] = init_word(i);
            if (p == 0) begin
                do_pair(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
                do_pair(1'b1, 1'b1, 32'h20, 32'h11, 1'b1, 1'b0, 32'h20, 32'h0);
            end else begin
                do_pair(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
                do_pair(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
                idle(2);
                do_pair(1'b1, 1'b1, 32'h24, 32'hCAFE, 1'b1, 1'b1, 32'h28, 32'hBEEF);
            end
            repeat (40) rand_pair();
            do_pair(1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            idle(2);
        end

        // Reset in the first wait cycle of a slot 0 load on the 3-cycle instance
        @(posedge clk); #1;
        mon_en = 1'b0;
        req0 = 1'b1; we0 = 1'b0; adr0 = 32'h1C;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall_o[cur]), 32'd0);
        chk("rst_mid_en", 32'(mem_en_o[cur]), 32'd0);
        chk("rst_mid_adr", mem_adr_o[cur], 32'd0);
        chk("rst_mid_rd0", rd0_o[cur], 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        accq.delete(); doneq.delete();
        held0 = 32'd0; held1 = 32'd0; cyc = 0;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        do_pair(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 32'h14, 32'h77);
        repeat (4) rand_pair();
        idle(2);
        @(negedge clk);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
